hilo_muldiv: RTL and testbench

Multi-cycle multiply/divide unit with the architectural HI/LO register pair for the harvard MIPS core. It is the consumer of the 5-bit `alucontrol` codes for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO, and sits beside the combinational ALU in the execute stage. It exposes `busy` so the hazard unit can stall the pipeline while an iterative operation is in flight.

---
 rtl/hilo_muldiv_if.sv | 28 ++
 rtl/hilo_muldiv.sv | 185 ++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: request/response bundle between the execute stage and the
// HI/LO multiply/divide unit.
//   start, alucontrol, srca, srcb : operation request (master -> slave)
//   busy, done                     : iterative-op status (slave -> master)
//   hi, lo, result                 : architectural HI/LO and MFHI/MFLO read path
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       alucontrol;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] result;

    modport master (
        output start, alucontrol, srca, srcb,
        input  busy, done, hi, lo, result
    );

    modport slave (
        input  start, alucontrol, srca, srcb,
        output busy, done, hi, lo, result
    );
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle multiply/divide unit owning the HI/LO pair.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset (clears FSM, HI, LO)
//   bus      : hilo_muldiv_if.slave
//              start/alucontrol/srca/srcb in; busy/done/hi/lo/result out
// MULT/MULTU use a one-bit-per-cycle shift-add, DIV/DIVU a restoring
// divider, both on operand magnitudes with sign fix-up on the last edge.
// Optional build macro: HILO_FAST_MULT_EN -- multiplies complete in a
// single cycle through a combinational multiplier; divide stays iterative.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    hilo_muldiv_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [4:0] OP_MULTU = 5'b00111;
    localparam logic [4:0] OP_MULT  = 5'b01000;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MTLO  = 5'b10010;
    localparam logic [4:0] OP_MFHI  = 5'b11010;
    localparam logic [4:0] OP_MFLO  = 5'b11011;

    typedef enum logic { IDLE, RUN } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    // operation context latched at acceptance
    logic               is_div_q;
    logic               neg_q;      // negate product / quotient
    logic               neg_r;      // negate remainder (dividend sign)
    logic               dz;         // divide by zero
    logic [WIDTH-1:0]   a_lat;

    // multiply datapath
    logic [2*WIDTH-1:0] mcand, prod;
    logic [WIDTH-1:0]   mplier;

    // divide datapath: quo shifts the dividend out as quotient bits shift in
    logic [WIDTH-1:0]   rem, quo, dvsr;

    // ---------------- operand decode ----------------
    logic             is_mul, is_signed, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        is_mul    = (bus.alucontrol == OP_MULT) || (bus.alucontrol == OP_MULTU);
        is_signed = (bus.alucontrol == OP_MULT) || (bus.alucontrol == OP_DIV);
        neg_a     = is_signed & bus.srca[WIDTH-1];
        neg_b     = is_signed & bus.srcb[WIDTH-1];
        mag_a     = neg_a ? -bus.srca : bus.srca;
        mag_b     = neg_b ? -bus.srcb : bus.srcb;
    end

    logic [2*WIDTH-1:0] fast_prod;
`ifdef HILO_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_mag;
    always_comb begin
        fast_mag  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
        fast_prod = (neg_a ^ neg_b) ? -fast_mag : fast_mag;
    end
    localparam bit FAST_MULT = 1'b1;
`else
    assign fast_prod = '0;
    localparam bit FAST_MULT = 1'b0;
`endif

    // ---------------- one iteration step ----------------
    logic [2*WIDTH-1:0] prod_nxt, prod_fin;
    logic [WIDTH:0]     sh;
    logic               ge;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt, rem_fin, quo_fin;

    always_comb begin
        prod_nxt = mplier[0] ? (prod + mcand) : prod;
        prod_fin = neg_q ? -prod_nxt : prod_nxt;

        // shifted partial remainder is < 2*dvsr, so the W-bit subtract is exact
        sh       = {rem, quo[WIDTH-1]};
        ge       = (sh >= {1'b0, dvsr});
        rem_nxt  = ge ? (sh[WIDTH-1:0] - dvsr) : sh[WIDTH-1:0];
        quo_nxt  = {quo[WIDTH-2:0], ge};
        rem_fin  = neg_r ? -rem_nxt : rem_nxt;
        quo_fin  = neg_q ? -quo_nxt : quo_nxt;
    end

    // ---------------- FSM + HI/LO ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            a_lat    <= '0;
            mcand    <= '0;
            prod     <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.alucontrol)
                            OP_MTHI: hi_q <= bus.srca;
                            OP_MTLO: lo_q <= bus.srca;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                if (FAST_MULT && is_mul) begin
                                    hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
                                    lo_q   <= fast_prod[WIDTH-1:0];
                                    done_q <= 1'b1;
                                end else begin
                                    state    <= RUN;
                                    busy_q   <= 1'b1;
                                    cnt      <= '0;
                                    is_div_q <= !is_mul;
                                    neg_q    <= neg_a ^ neg_b;
                                    neg_r    <= neg_a;
                                    dz       <= (bus.srcb == '0);
                                    a_lat    <= bus.srca;
                                    mcand    <= {{WIDTH{1'b0}}, mag_a};
                                    mplier   <= mag_b;
                                    prod     <= '0;
                                    rem      <= '0;
                                    quo      <= mag_a;
                                    dvsr     <= mag_b;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt    <= cnt + 1'b1;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    prod   <= prod_nxt;
                    rem    <= rem_nxt;
                    quo    <= quo_nxt;
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        cnt    <= '0;
                        if (!is_div_q) begin
                            hi_q <= prod_fin[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fin[WIDTH-1:0];
                        end else if (dz) begin
                            // divide by zero: HI keeps the dividend, LO all ones
                            hi_q <= a_lat;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fin;
                            lo_q <= quo_fin;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.result = (bus.alucontrol == OP_MFHI) ? hi_q :
                        (bus.alucontrol == OP_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: randomized + directed self-checking bench for hilo_muldiv.
// Expected HI/LO come from native signed/unsigned arithmetic in model().
module tb_hilo_muldiv;
    localparam logic [4:0] MULTU = 5'b00111;
    localparam logic [4:0] MULT  = 5'b01000;
    localparam logic [4:0] DIV   = 5'b01111;
    localparam logic [4:0] DIVU  = 5'b10000;
    localparam logic [4:0] MTHI  = 5'b10001;
    localparam logic [4:0] MTLO  = 5'b10010;
    localparam logic [4:0] MFHI  = 5'b11010;
    localparam logic [4:0] MFLO  = 5'b11011;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(32)) bus ();
    hilo_muldiv #(.WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl_hi = 32'h0;
    logic [31:0] mdl_lo = 32'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference: {hi, lo}
    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'h0;
        case (op)
            MULTU: p = {32'h0, a} * {32'h0, b};
            MULT:  p = 64'(sa * sb);
            DIVU:  p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            DIV: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {32'(r), 32'(q)};
                end
            end
            default: p = 64'h0;
        endcase
        return p;
    endfunction

    function automatic int exp_busy(input logic [4:0] op);
`ifdef HILO_FAST_MULT_EN
        if (op == MULT || op == MULTU) return 0;
`endif
        return 32;
    endfunction

    // drive one op, then wait for busy to drop (bounded)
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output logic done_now);
        bus.start = 1'b1; bus.alucontrol = op; bus.srca = a; bus.srcb = b;
        tick();
        bus.start = 1'b0; bus.alucontrol = 5'b0;
        bus.srca = $urandom; bus.srcb = $urandom;
        nbusy = 0;
        while (bus.busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            tick();
        end
        done_now = bus.done;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.alucontrol = MFHI; bus.srca = '0; bus.srcb = '0;
        reset_n = 1'b0;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        reset_n = 1'b1;
        tick();
        mdl_hi = 0; mdl_lo = 0;
    endtask

    task automatic test_mt;
        logic [31:0] v;
        bus.start = 1'b1; bus.alucontrol = MTHI; bus.srca = 32'h12345678;
        tick();
        bus.start = 1'b0; bus.alucontrol = MFHI; bus.srca = $urandom;
        #1;
        mdl_hi = 32'h12345678;
        checks++; if (bus.result !== mdl_hi) begin failures++; $display("FAIL mfhi_after_mthi got=%h exp=%h", bus.result, mdl_hi); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL mthi_flags busy=%b done=%b exp=0,0", bus.busy, bus.done); end
        tick();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mthi_done_later got=%b exp=0", bus.done); end
        v = $urandom;
        bus.start = 1'b1; bus.alucontrol = MTLO; bus.srca = v;
        tick();
        bus.start = 1'b0; bus.alucontrol = MFLO;
        #1;
        mdl_lo = v;
        checks++; if (bus.result !== mdl_lo || bus.hi !== mdl_hi) begin failures++; $display("FAIL mflo_after_mtlo got=%h/%h exp=%h/%h", bus.result, bus.hi, mdl_lo, mdl_hi); end
    endtask

    task automatic test_directed;
        logic [4:0]  ops [5] = '{MULTU, MULT, DIV, DIVU, DIV};
        logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000};
        logic [31:0] bs  [5] = '{32'd2, 32'd5, 32'd2, 32'd0, 32'hFFFFFFFF};
        logic [63:0] want [5] = '{64'h00000001_FFFFFFFE, 64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFF_FFFFFFFD,
                                  64'h00000064_FFFFFFFF, 64'h00000000_80000000};
        int nb;
        logic dn;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], nb, dn);
            checks++; if (nb !== exp_busy(ops[i])) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, nb, exp_busy(ops[i])); end
            checks++; if (dn !== 1'b1) begin failures++; $display("FAIL dir%0d_done got=%b exp=1", i, dn); end
            checks++; if ({bus.hi, bus.lo} !== want[i]) begin failures++; $display("FAIL dir%0d_hilo got=%h exp=%h", i, {bus.hi, bus.lo}, want[i]); end
            tick();
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, bus.done); end
            {mdl_hi, mdl_lo} = want[i];
        end
    endtask

    task automatic test_random;
        logic [4:0]  pick [4] = '{MULT, MULTU, DIV, DIVU};
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [63:0] e;
        int nb;
        logic dn;
        for (int i = 0; i < 24; i++) begin
            op = pick[$urandom_range(0, 3)];
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            e = model(op, a, b);
            run_op(op, a, b, nb, dn);
            checks++; if (nb !== exp_busy(op) || dn !== 1'b1) begin failures++; $display("FAIL rnd%0d_timing busy=%0d done=%b exp=%0d,1", i, nb, dn, exp_busy(op)); end
            checks++; if ({bus.hi, bus.lo} !== e) begin failures++; $display("FAIL rnd%0d_hilo op=%b a=%h b=%h got=%h exp=%h", i, op, a, b, {bus.hi, bus.lo}, e); end
            {mdl_hi, mdl_lo} = e;
            tick();
        end
    endtask

    task automatic test_busy_ignore;
        int total;
        bus.start = 1'b1; bus.alucontrol = DIVU; bus.srca = 32'd9; bus.srcb = 32'd2;
        tick();
        bus.start = 1'b0; bus.alucontrol = 5'b0;
        total = 0;
        while (bus.busy === 1'b1 && total < 40) begin
            total++;
            if (total == 5) begin
                bus.start = 1'b1; bus.alucontrol = MTLO; bus.srca = 32'hAAAA;
            end
            if (total == 10) begin
                bus.alucontrol = MFHI;
                #1;
                checks++; if (bus.result !== mdl_hi) begin failures++; $display("FAIL busy_mfhi_pre got=%h exp=%h", bus.result, mdl_hi); end
            end
            tick();
            if (total == 5) begin
                bus.start = 1'b0; bus.alucontrol = 5'b0;
                checks++; if (bus.lo !== mdl_lo || bus.busy !== 1'b1) begin failures++; $display("FAIL busy_mtlo_ignored lo=%h busy=%b exp=%h,1", bus.lo, bus.busy, mdl_lo); end
            end
        end
        checks++; if (total !== 32) begin failures++; $display("FAIL busy_ignore_cycles got=%0d exp=32", total); end
        checks++; if (bus.lo !== 32'd4 || bus.hi !== 32'd1 || bus.done !== 1'b1) begin failures++; $display("FAIL busy_ignore_result hi=%h lo=%h done=%b exp=1,4,1", bus.hi, bus.lo, bus.done); end
        mdl_hi = 32'd1; mdl_lo = 32'd4;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        logic [63:0] e1, e2;
        int nb;
        logic dn;
        a = $urandom; b = $urandom_range(1, 1000);
        e1 = model(DIVU, a, b);
        run_op(DIVU, a, b, nb, dn);
        checks++; if (dn !== 1'b1 || {bus.hi, bus.lo} !== e1) begin failures++; $display("FAIL b2b_first done=%b got=%h exp=%h", dn, {bus.hi, bus.lo}, e1); end
        // new start in the done cycle
        a = $urandom; b = $urandom;
        e2 = model(DIV, a, b);
        bus.start = 1'b1; bus.alucontrol = DIV; bus.srca = a; bus.srcb = b;
        tick();
        bus.start = 1'b0; bus.alucontrol = 5'b0; bus.srca = $urandom; bus.srcb = $urandom;
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || {bus.hi, bus.lo} !== e1) begin failures++; $display("FAIL b2b_accept busy=%b done=%b hilo=%h exp=1,0,%h", bus.busy, bus.done, {bus.hi, bus.lo}, e1); end
        nb = 0;
        while (bus.busy === 1'b1 && nb < 40) begin nb++; tick(); end
        checks++; if (nb !== 32 || bus.done !== 1'b1 || {bus.hi, bus.lo} !== e2) begin failures++; $display("FAIL b2b_second busy=%0d done=%b got=%h exp=32,1,%h", nb, bus.done, {bus.hi, bus.lo}, e2); end
        {mdl_hi, mdl_lo} = e2;
        tick();
    endtask

    task automatic test_bad_op;
        bus.start = 1'b1; bus.alucontrol = 5'b00000; bus.srca = $urandom; bus.srcb = $urandom;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== mdl_hi || bus.lo !== mdl_lo) begin failures++; $display("FAIL bad_op busy=%b done=%b hi=%h lo=%h exp=0,0,%h,%h", bus.busy, bus.done, bus.hi, bus.lo, mdl_hi, mdl_lo); end
        tick();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL bad_op_done got=%b exp=0", bus.done); end
    endtask

    task automatic test_reset_mid;
        int nb;
        logic dn;
        bus.start = 1'b1; bus.alucontrol = MULTU; bus.srca = $urandom | 32'h1; bus.srcb = $urandom | 32'h1;
        tick();
        bus.start = 1'b0; bus.alucontrol = 5'b0;
        for (int i = 0; i < 9; i++) tick();
        reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin failures++; $display("FAIL mid_reset busy=%b done=%b hi=%h lo=%h exp=all 0", bus.busy, bus.done, bus.hi, bus.lo); end
        tick();
        reset_n = 1'b1;
        tick();
        run_op(MULTU, 32'd3, 32'd3, nb, dn);
        checks++; if (nb !== exp_busy(MULTU) || bus.lo !== 32'd9 || bus.hi !== 32'h0) begin failures++; $display("FAIL after_reset_mult busy=%0d hi=%h lo=%h exp=%0d,0,9", nb, bus.hi, bus.lo, exp_busy(MULTU)); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mt();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_bad_op();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
